// File: rtl/cva6_hpdcache_icache_pkg.sv
// Shared definitions for the I$ port of the HPDcache memory subsystem.
// Holds the I$ transaction id, request-field encodings, beat/size helpers
// and the memory request/response structures seen by the I$ side.
package cva6_hpdcache_icache_pkg;

  // Subset of the CVA6 configuration needed by the I$ memory path
  typedef struct packed {
    int unsigned PLEN;
    int unsigned ICACHE_LINE_WIDTH;
    int unsigned ICACHE_SET_ASSOC;
    int unsigned FETCH_WIDTH;
    int unsigned MEM_TID_WIDTH;
  } icache_cfg_t;

  localparam icache_cfg_t ICACHE_CFG_DEFAULT = '{
    PLEN:              56,
    ICACHE_LINE_WIDTH: 128,
    ICACHE_SET_ASSOC:  4,
    FETCH_WIDTH:       32,
    MEM_TID_WIDTH:     4
  };

  // Memory interface field widths
  localparam int unsigned MEM_ADDR_WIDTH   = ICACHE_CFG_DEFAULT.PLEN;
  localparam int unsigned MEM_ID_WIDTH     = ICACHE_CFG_DEFAULT.MEM_TID_WIDTH;
  localparam int unsigned MEM_DATA_WIDTH   = 64;
  localparam int unsigned MEM_LEN_WIDTH    = 8;
  localparam int unsigned MEM_SIZE_WIDTH   = 3;
  localparam int unsigned MEM_CMD_WIDTH    = 2;
  localparam int unsigned MEM_ATOMIC_WIDTH = 4;

  // Transaction id reserved for the instruction cache (MSB of the id set)
  localparam logic [MEM_ID_WIDTH-1:0] ICACHE_TID = MEM_ID_WIDTH'(1) << (MEM_ID_WIDTH - 1);

  // Request command encodings
  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_READ   = 2'b00;
  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_WRITE  = 2'b01;
  localparam logic [MEM_CMD_WIDTH-1:0] MEM_CMD_ATOMIC = 2'b10;

  localparam logic [MEM_ATOMIC_WIDTH-1:0] MEM_ATOMIC_NONE = 4'h0;

  // Request size encodings (log2 of the byte count)
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_1B  = 3'd0;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_2B  = 3'd1;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_4B  = 3'd2;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_8B  = 3'd3;
  localparam logic [MEM_SIZE_WIDTH-1:0] MEM_SIZE_16B = 3'd4;

  // Number of memory beats that make up one cache line
  function automatic int unsigned beat_count(input int unsigned line_width,
                                             input int unsigned beat_width);
    return line_width / beat_width;
  endfunction

  // Size code for a transfer of the given number of bytes
  function automatic logic [MEM_SIZE_WIDTH-1:0] size_code(input int unsigned bytes);
    return MEM_SIZE_WIDTH'($clog2(bytes));
  endfunction

  typedef struct packed {
    logic [MEM_ADDR_WIDTH-1:0]   mem_req_addr;
    logic [MEM_LEN_WIDTH-1:0]    mem_req_len;
    logic [MEM_SIZE_WIDTH-1:0]   mem_req_size;
    logic [MEM_ID_WIDTH-1:0]     mem_req_id;
    logic [MEM_CMD_WIDTH-1:0]    mem_req_command;
    logic [MEM_ATOMIC_WIDTH-1:0] mem_req_atomic;
    logic                        mem_req_cacheable;
  } icache_mem_req_t;

  typedef struct packed {
    logic                      mem_resp_r_error;
    logic [MEM_ID_WIDTH-1:0]   mem_resp_r_id;
    logic [MEM_DATA_WIDTH-1:0] mem_resp_r_data;
    logic                      mem_resp_r_last;
  } icache_mem_resp_r_t;

  // Line assembler transaction states
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP,
    DONE
  } asm_state_e;

endpackage

// File: rtl/cva6_icache_mem_line_assembler.sv
// Turns one I$ miss into a memory read request and reassembles the
// multi-beat read response into a full I$ line. One transaction in flight;
// a kill lets the memory handshake finish but drops the returned data.
module cva6_icache_mem_line_assembler
  import cva6_hpdcache_icache_pkg::*;
#(
  parameter icache_cfg_t CVA6Cfg      = ICACHE_CFG_DEFAULT,
  parameter int unsigned MemDataWidth = 64,
  parameter type hpdcache_mem_req_t    = icache_mem_req_t,
  parameter type hpdcache_mem_resp_r_t = icache_mem_resp_r_t
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   miss_valid_i,
  output logic                                   miss_ready_o,
  input  logic [CVA6Cfg.PLEN-1:0]                miss_paddr_i,
  input  logic                                   miss_nc_i,
  input  logic [CVA6Cfg.ICACHE_SET_ASSOC-1:0]    miss_way_i,
  input  logic                                   kill_i,
  output logic                                   line_valid_o,
  input  logic                                   line_ready_i,
  output logic [CVA6Cfg.ICACHE_LINE_WIDTH-1:0]   line_o,
  output logic [CVA6Cfg.ICACHE_SET_ASSOC-1:0]    line_way_o,
  output logic                                   line_nc_o,
  output logic                                   line_error_o,
  output logic                                   mem_req_valid_o,
  input  logic                                   mem_req_ready_i,
  output hpdcache_mem_req_t                      mem_req_o,
  input  logic                                   mem_resp_valid_i,
  output logic                                   mem_resp_ready_o,
  input  hpdcache_mem_resp_r_t                   mem_resp_i
);

  localparam int unsigned PLEN      = CVA6Cfg.PLEN;
  localparam int unsigned LINE_W    = CVA6Cfg.ICACHE_LINE_WIDTH;
  localparam int unsigned WAYS      = CVA6Cfg.ICACHE_SET_ASSOC;
  localparam int unsigned BEATS     = beat_count(LINE_W, MemDataWidth);
  localparam int unsigned CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned LINE_OFF  = $clog2(LINE_W / 8);
  localparam int unsigned FETCH_OFF = $clog2(CVA6Cfg.FETCH_WIDTH / 8);

  localparam logic [CNT_W-1:0]          LAST_CNT   = CNT_W'(BEATS - 1);
  localparam logic [MEM_LEN_WIDTH-1:0]  LINE_LEN   = MEM_LEN_WIDTH'(BEATS - 1);
  localparam logic [MEM_SIZE_WIDTH-1:0] BEAT_SIZE  = size_code(MemDataWidth / 8);
  localparam logic [MEM_SIZE_WIDTH-1:0] FETCH_SIZE = size_code(CVA6Cfg.FETCH_WIDTH / 8);
  localparam logic [PLEN-1:0] LINE_MASK  = ~((PLEN'(1) << LINE_OFF) - PLEN'(1));
  localparam logic [PLEN-1:0] FETCH_MASK = ~((PLEN'(1) << FETCH_OFF) - PLEN'(1));

  asm_state_e        state_d, state_q;
  logic [PLEN-1:0]   paddr_d, paddr_q;
  logic              nc_d, nc_q;
  logic [WAYS-1:0]   way_d, way_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic              error_d, error_q;
  logic              kill_d, kill_q;
  logic [LINE_W-1:0] line_d, line_q;

  logic [PLEN-1:0]   req_addr;
  logic              dropping;

  // A transaction whose data must not reach the cache
  assign dropping = kill_q | kill_i;

  // Cacheable misses fetch the whole line, uncached ones a single fetch word
  assign req_addr = paddr_q & (nc_q ? FETCH_MASK : LINE_MASK);

  assign line_o       = line_q;
  assign line_way_o   = way_q;
  assign line_nc_o    = nc_q;
  assign line_error_o = error_q;

  // Next-state, beat assembly and handshake outputs decoded from the registered state
  always_comb begin
    state_d = state_q;
    paddr_d = paddr_q;
    nc_d    = nc_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    error_d = error_q;
    kill_d  = kill_q;
    line_d  = line_q;

    miss_ready_o     = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    line_valid_o     = 1'b0;

    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          paddr_d = miss_paddr_i;
          nc_d    = miss_nc_i;
          way_d   = miss_way_i;
          cnt_d   = '0;
          error_d = 1'b0;
          kill_d  = 1'b0;
          state_d = REQ;
        end
      end

      REQ: begin
        mem_req_valid_o = 1'b1;
        if (kill_i) begin
          kill_d = 1'b1;
        end
        if (mem_req_ready_i) begin
          state_d = RESP;
        end
      end

      RESP: begin
        mem_resp_ready_o = 1'b1;
        if (kill_i) begin
          kill_d = 1'b1;
        end
        if (mem_resp_valid_i) begin
          if (!dropping) begin
            for (int unsigned i = 0; i < BEATS; i++) begin
              if (nc_q || (cnt_q == CNT_W'(i))) begin
                line_d[i*MemDataWidth +: MemDataWidth] = mem_resp_i.mem_resp_r_data;
              end
            end
            error_d = error_q | mem_resp_i.mem_resp_r_error;
          end
          if (cnt_q != LAST_CNT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (mem_resp_i.mem_resp_r_last) begin
            state_d = dropping ? IDLE : DONE;
          end
        end
      end

      DONE: begin
        line_valid_o = 1'b1;
        if (line_ready_i || kill_i) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Read request fields; driven only while the request is being offered
  always_comb begin
    mem_req_o = '0;
    if (state_q == REQ) begin
      mem_req_o.mem_req_addr      = MEM_ADDR_WIDTH'(req_addr);
      mem_req_o.mem_req_len       = nc_q ? '0 : LINE_LEN;
      mem_req_o.mem_req_size      = nc_q ? FETCH_SIZE : BEAT_SIZE;
      mem_req_o.mem_req_id        = ICACHE_TID;
      mem_req_o.mem_req_command   = MEM_CMD_READ;
      mem_req_o.mem_req_atomic    = MEM_ATOMIC_NONE;
      mem_req_o.mem_req_cacheable = ~nc_q;
    end
  end

  // State, transaction context and line buffer registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      paddr_q <= '0;
      nc_q    <= 1'b0;
      way_q   <= '0;
      cnt_q   <= '0;
      error_q <= 1'b0;
      kill_q  <= 1'b0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      paddr_q <= paddr_d;
      nc_q    <= nc_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
      kill_q  <= kill_d;
      line_q  <= line_d;
    end
  end

`ifndef SYNTHESIS
  // Every response routed to this port must belong to the I$ transaction id
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == RESP && mem_resp_valid_i) |-> (mem_resp_i.mem_resp_r_id == ICACHE_TID));
`endif

endmodule

// File: tb/tb_cva6_icache_mem_line_assembler.sv
// Directed self-checking bench for the I$ memory line assembler.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cva6_icache_mem_line_assembler;
  import cva6_hpdcache_icache_pkg::*;

  logic               clk;
  logic               rst_n;
  logic               miss_valid_i;
  logic               miss_ready_o;
  logic [55:0]        miss_paddr_i;
  logic               miss_nc_i;
  logic [3:0]         miss_way_i;
  logic               kill_i;
  logic               line_valid_o;
  logic               line_ready_i;
  logic [127:0]       line_o;
  logic [3:0]         line_way_o;
  logic               line_nc_o;
  logic               line_error_o;
  logic               mem_req_valid_o;
  logic               mem_req_ready_i;
  icache_mem_req_t    mem_req_o;
  logic               mem_resp_valid_i;
  logic               mem_resp_ready_o;
  icache_mem_resp_r_t mem_resp_i;

  int numTests  = 0;
  int numFailed = 0;

  cva6_icache_mem_line_assembler #(
    .MemDataWidth(64)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .miss_valid_i    (miss_valid_i),
    .miss_ready_o    (miss_ready_o),
    .miss_paddr_i    (miss_paddr_i),
    .miss_nc_i       (miss_nc_i),
    .miss_way_i      (miss_way_i),
    .kill_i          (kill_i),
    .line_valid_o    (line_valid_o),
    .line_ready_i    (line_ready_i),
    .line_o          (line_o),
    .line_way_o      (line_way_o),
    .line_nc_o       (line_nc_o),
    .line_error_o    (line_error_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_o       (mem_req_o),
    .mem_resp_valid_i(mem_resp_valid_i),
    .mem_resp_ready_o(mem_resp_ready_o),
    .mem_resp_i      (mem_resp_i)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    numTests++;
    if (observed !== expected) begin
      numFailed++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present a miss for one cycle; returns at the falling edge of the REQ cycle
  task automatic applyStimulus(input logic [55:0] paddr, input logic nc, input logic [3:0] way);
    checkOutput("miss_ready_idle", miss_ready_o, 1'b1);
    miss_valid_i = 1'b1;
    miss_paddr_i = paddr;
    miss_nc_i    = nc;
    miss_way_i   = way;
    @(negedge clk);
    miss_valid_i = 1'b0;
    miss_paddr_i = '0;
    miss_nc_i    = 1'b0;
    miss_way_i   = '0;
    checkOutput("req_valid_next_cycle", mem_req_valid_o, 1'b1);
  endtask

  task automatic acceptRequest();
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    checkOutput("req_valid_dropped", mem_req_valid_o, 1'b0);
  endtask

  task automatic sendBeat(input logic [63:0] data, input logic last, input logic err,
                          input logic kill);
    checkOutput("beat_resp_ready", mem_resp_ready_o, 1'b1);
    mem_resp_valid_i            = 1'b1;
    mem_resp_i.mem_resp_r_data  = data;
    mem_resp_i.mem_resp_r_last  = last;
    mem_resp_i.mem_resp_r_error = err;
    mem_resp_i.mem_resp_r_id    = 4'h8;
    kill_i                      = kill;
    @(negedge clk);
    mem_resp_valid_i = 1'b0;
    mem_resp_i       = '0;
    kill_i           = 1'b0;
  endtask

  task automatic finishLine();
    line_ready_i = 1'b1;
    @(negedge clk);
    line_ready_i = 1'b0;
    checkOutput("line_valid_after_hs", line_valid_o, 1'b0);
    checkOutput("miss_ready_after_hs", miss_ready_o, 1'b1);
  endtask

  initial begin
    rst_n            = 1'b0;
    miss_valid_i     = 1'b0;
    miss_paddr_i     = '0;
    miss_nc_i        = 1'b0;
    miss_way_i       = '0;
    kill_i           = 1'b0;
    line_ready_i     = 1'b0;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_i       = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_miss_ready", miss_ready_o, 1'b1);
    checkOutput("rst_req_valid", mem_req_valid_o, 1'b0);
    checkOutput("rst_resp_ready", mem_resp_ready_o, 1'b0);
    checkOutput("rst_line_valid", line_valid_o, 1'b0);
    checkOutput("rst_line", line_o, 128'h0);
    checkOutput("rst_mem_req", mem_req_o, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Cacheable miss, two beats
    applyStimulus(56'h8000_0014, 1'b0, 4'b0010);
    checkOutput("c_addr", mem_req_o.mem_req_addr, 56'h8000_0010);
    checkOutput("c_len", mem_req_o.mem_req_len, 8'd1);
    checkOutput("c_size", mem_req_o.mem_req_size, 3'd3);
    checkOutput("c_id", mem_req_o.mem_req_id, 4'h8);
    checkOutput("c_cmd", mem_req_o.mem_req_command, 2'b00);
    checkOutput("c_atomic", mem_req_o.mem_req_atomic, 4'h0);
    checkOutput("c_cacheable", mem_req_o.mem_req_cacheable, 1'b1);
    checkOutput("c_resp_ready_in_req", mem_resp_ready_o, 1'b0);
    acceptRequest();
    sendBeat(64'hA, 1'b0, 1'b0, 1'b0);
    checkOutput("c_no_line_before_last", line_valid_o, 1'b0);
    sendBeat(64'hB, 1'b1, 1'b0, 1'b0);
    checkOutput("c_line_valid", line_valid_o, 1'b1);
    checkOutput("c_line", line_o, {64'hB, 64'hA});
    checkOutput("c_error", line_error_o, 1'b0);
    checkOutput("c_way", line_way_o, 4'b0010);
    checkOutput("c_nc", line_nc_o, 1'b0);
    finishLine();

    // Non-cacheable miss, single replicated beat
    applyStimulus(56'h1000_0004, 1'b1, 4'b1000);
    checkOutput("nc_addr", mem_req_o.mem_req_addr, 56'h1000_0004);
    checkOutput("nc_len", mem_req_o.mem_req_len, 8'd0);
    checkOutput("nc_size", mem_req_o.mem_req_size, 3'd2);
    checkOutput("nc_cacheable", mem_req_o.mem_req_cacheable, 1'b0);
    acceptRequest();
    sendBeat(64'h1234, 1'b1, 1'b0, 1'b0);
    checkOutput("nc_line_valid", line_valid_o, 1'b1);
    checkOutput("nc_line", line_o, {64'h1234, 64'h1234});
    checkOutput("nc_nc", line_nc_o, 1'b1);
    checkOutput("nc_way", line_way_o, 4'b1000);
    finishLine();

    // Stalled request, killed in REQ, beats drained without a line
    applyStimulus(56'h8000_0040, 1'b0, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_req_valid", mem_req_valid_o, 1'b1);
      checkOutput("stall_req_addr", mem_req_o.mem_req_addr, 56'h8000_0040);
      checkOutput("stall_resp_ready", mem_resp_ready_o, 1'b0);
      @(negedge clk);
    end
    kill_i = 1'b1;
    @(negedge clk);
    kill_i = 1'b0;
    checkOutput("kill_req_valid", mem_req_valid_o, 1'b1);
    checkOutput("kill_req_len", mem_req_o.mem_req_len, 8'd1);
    acceptRequest();
    sendBeat(64'hC0, 1'b0, 1'b0, 1'b0);
    checkOutput("kill_no_line_mid", line_valid_o, 1'b0);
    sendBeat(64'hC1, 1'b1, 1'b0, 1'b0);
    checkOutput("kill_no_line", line_valid_o, 1'b0);
    checkOutput("kill_back_idle", miss_ready_o, 1'b1);
    checkOutput("kill_resp_ready_off", mem_resp_ready_o, 1'b0);

    // Error on the second beat, consumer stalls for three cycles
    applyStimulus(56'h8000_0100, 1'b0, 4'b0100);
    acceptRequest();
    sendBeat(64'h1111, 1'b0, 1'b0, 1'b0);
    sendBeat(64'h2222, 1'b1, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      checkOutput("err_line_valid", line_valid_o, 1'b1);
      checkOutput("err_line", line_o, {64'h2222, 64'h1111});
      checkOutput("err_way", line_way_o, 4'b0100);
      checkOutput("err_flag", line_error_o, 1'b1);
      @(negedge clk);
    end
    finishLine();

    // Kill together with the last beat, then an immediate new miss
    applyStimulus(56'h8000_0200, 1'b0, 4'b0001);
    acceptRequest();
    sendBeat(64'h3333, 1'b0, 1'b0, 1'b0);
    sendBeat(64'h4444, 1'b1, 1'b0, 1'b1);
    checkOutput("klast_no_line", line_valid_o, 1'b0);
    applyStimulus(56'h8000_0300, 1'b0, 4'b0010);
    checkOutput("klast2_addr", mem_req_o.mem_req_addr, 56'h8000_0300);
    acceptRequest();
    sendBeat(64'h5555, 1'b0, 1'b0, 1'b0);
    sendBeat(64'h6666, 1'b1, 1'b0, 1'b0);
    checkOutput("klast2_line_valid", line_valid_o, 1'b1);
    checkOutput("klast2_line", line_o, {64'h6666, 64'h5555});
    checkOutput("klast2_way", line_way_o, 4'b0010);
    checkOutput("klast2_error", line_error_o, 1'b0);
    finishLine();

    // Asynchronous reset in the middle of the response phase
    applyStimulus(56'h8000_0400, 1'b0, 4'b1000);
    acceptRequest();
    sendBeat(64'h7777, 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_miss_ready", miss_ready_o, 1'b1);
    checkOutput("arst_resp_ready", mem_resp_ready_o, 1'b0);
    checkOutput("arst_req_valid", mem_req_valid_o, 1'b0);
    checkOutput("arst_line_valid", line_valid_o, 1'b0);
    checkOutput("arst_line", line_o, 128'h0);
    checkOutput("arst_way", line_way_o, 4'b0000);
    checkOutput("arst_nc", line_nc_o, 1'b0);
    checkOutput("arst_error", line_error_o, 1'b0);
    checkOutput("arst_mem_req", mem_req_o, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(56'h8000_0528, 1'b0, 4'b0100);
    checkOutput("post_rst_addr", mem_req_o.mem_req_addr, 56'h8000_0520);
    acceptRequest();
    sendBeat(64'h9999, 1'b0, 1'b0, 1'b0);
    sendBeat(64'hAAAA, 1'b1, 1'b0, 1'b0);
    checkOutput("post_rst_line_valid", line_valid_o, 1'b1);
    checkOutput("post_rst_line", line_o, {64'hAAAA, 64'h9999});
    checkOutput("post_rst_way", line_way_o, 4'b0100);
    checkOutput("post_rst_error", line_error_o, 1'b0);
    finishLine();

    $display("[TB] %0d tests run, %0d failed", numTests, numFailed);
    $finish;
  end

endmodule
